alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one combinational ALU datapath between NREQ requesters (e.g. the integer pipe and the branch-compare unit) in the MIPS core. Performs round-robin arbitration with valid/ready handshakes, registers the operands and result, and returns the result and a correct zero flag to the granted requester. It sits between the requesters and the ALU and owns all sequencing of the shared datapath.

## Interface
- NREQ, 2, number of requesters (legal 2..4)
- WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NREQ  request valid, one bit per requester
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- req_a  in  NREQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- req_op  in  NREQ*3  ALU opcode; requester i at [i*3 +: 3]
- rsp_valid  out  NREQ  result valid, one-hot to the owning requester
- rsp_ready  in  NREQ  requester accepts result
- rsp_y  out  WIDTH  result (shared bus)
- rsp_z  out  1  zero flag, 1 iff rsp_y == 0

## Operation
- Opcodes:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 xor
  - 101 nor
  - 110 slt (signed)
  - 111 sltu (unsigned)
- Arithmetic: add/sub wrap modulo 2^WIDTH, no overflow flag. slt/sltu produce Y = 1 or 0, zero-extended to WIDTH. Z = (Y == 0) for every opcode.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid, the arbiter picks winner g.
  - req_ready[g] = 1 in the same cycle (combinational from req_valid, state, and pointer).
  - Operands, opcode, and g are captured; next state is EXEC.
  - With no valid requests, the block stays in IDLE.
- EXEC: the ALU evaluates the captured operands; Y and Z are registered into rsp_y/rsp_z. Next state is RESP.
- RESP:
  - rsp_valid[g] = 1; rsp_y/rsp_z are held stable.
  - On rsp_ready[g] the next state is IDLE and the round-robin pointer becomes g+1 mod NREQ.
  - rsp_ready of other requesters is ignored.
- Round-robin: the search starts at the pointer and ascends with wrap. The first requester found with valid set wins.
- req_ready is 0 in EXEC and RESP; requests stay pending. A requester may drop req_valid before it is granted; nothing is captured in that case.
- Only one transaction is in flight at a time.

## Timing
- Reset values:
  - state = IDLE
  - pointer = 0
  - req_ready = 0
  - rsp_valid = 0
  - rsp_y = 0
  - rsp_z = 0
- Latency: accept in cycle T (IDLE), result registered at the end of T+1, rsp_valid high from T+2.
- Throughput: at most one op per 3 cycles when rsp_ready is already high at T+2. The next accept is possible at T+3.
- Backpressure: rsp_valid is held for as long as rsp_ready[g] is 0, with no timeout.
- Simultaneous requests: in IDLE, exactly one requester is granted per the pointer. The others are served in later rounds; no requester waits more than NREQ-1 transactions.
- Reset mid-operation (EXEC/RESP): the transaction is dropped, outputs return to reset values immediately, and the pointer returns to 0.
- An illegal opcode cannot occur; all 8 codes are defined.

## Configuration
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index valid requester always wins, and the pointer logic is removed.
- Undefined (default): round-robin as specified above.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  - the FSM state typedef/encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2
- Sub-module rr_arb (NREQ-wide):
  - takes the request vector and pointer, returns a one-hot grant
  - is compiled to fixed priority under ALU_ARB_FIXED_PRIO_EN
- The ALU function is evaluated as a combinational case on the captured opcode inside alu_arbiter.

## Test plan
- Reset: hold rst_n=0 with req_valid=2'b11 -> all outputs 0. After release, the first grant goes to requester 0.
- Basic op: r0 requests add A=32'h7FFFFFFF, B=1 at T -> req_ready[0] at T; rsp_valid[0] at T+2 with Y=32'h80000000, Z=0. Sub 5-5 -> Y=0, Z=1.
- Compare ops: slt A=32'hFFFFFFFF, B=1 -> Y=1. sltu with the same operands -> Y=0, Z=1. nor 0,0 -> Y=32'hFFFFFFFF.
- Contention: both requesters valid continuously -> grants alternate 0,1,0,1; each rsp_valid is one-hot to the correct owner. With ALU_ARB_FIXED_PRIO_EN defined -> always 0.
- Backpressure: hold rsp_ready[1]=0 for 5 cycles -> rsp_valid[1] and rsp_y stay stable and req_ready stays 0. Releasing rsp_ready -> IDLE next cycle.
- Reset mid-op: assert rst_n=0 during EXEC -> rsp_valid never rises. After release, a new request completes normally.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcode values and FSM state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_NOR  = 3'd5;
    localparam logic [2:0] ALU_SLT  = 3'd6;
    localparam logic [2:0] ALU_SLTU = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters and the shared ALU arbiter.
interface alu_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*3-1:0]     req_op;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]      rsp_y;
    logic                  rsp_z;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_z
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_z
    );
endinterface

// File: rtl/alu_arbiter_rr_arb.sv
// One-hot grant picker: round-robin from ptr, or lowest-index fixed priority
// when ALU_ARB_FIXED_PRIO_EN is defined (ptr port then disappears).
module rr_arb #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic [$clog2(NREQ)-1:0] ptr,
`endif
    output logic [NREQ-1:0]         grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = req & (~req + NREQ'(1));
    end
`else
    logic [NREQ-1:0] below;
    logic [NREQ-1:0] upper;
    logic [NREQ-1:0] cand;

    // Requests at or above ptr win first; otherwise wrap to the lowest index.
    always_comb begin
        below = (NREQ'(1) << ptr) - NREQ'(1);
        upper = req & ~below;
        cand  = (upper != '0) ? upper : req;
        grant = cand & (~cand + NREQ'(1));
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters: accept, execute, respond, one op in flight.
// ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module alu_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    import alu_pkg::*;

    localparam int PW = $clog2(NREQ);

    state_t           state;
    state_t           next;
    logic [NREQ-1:0]  grant;
    logic [PW-1:0]    g_idx;
    logic [PW-1:0]    g_q;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] y_q;
    logic             z_q;
    logic             accept;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [PW-1:0]    ptr;
`endif

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req   (bus.req_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
        .ptr   (ptr),
`endif
        .grant (grant)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = ALU_ADD;
        g_idx  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a  = bus.req_a[i*WIDTH +: WIDTH];
                sel_b  = bus.req_b[i*WIDTH +: WIDTH];
                sel_op = bus.req_op[i*3 +: 3];
                g_idx  = PW'(i);
            end
        end
    end

    // req_ready is masked by rst_n so it reads 0 while reset is held.
    always_comb begin
        next          = state;
        accept        = 1'b0;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        case (state)
            IDLE: begin
                if (rst_n && bus.req_valid != '0) begin
                    bus.req_ready = grant;
                    accept        = 1'b1;
                    next          = EXEC;
                end
            end
            EXEC: next = RESP;
            RESP: begin
                bus.rsp_valid[g_q] = 1'b1;
                if (bus.rsp_ready[g_q]) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_comb begin
        alu_y = '0;
        case (op_q)
            ALU_ADD:  alu_y = a_q + b_q;
            ALU_SUB:  alu_y = a_q - b_q;
            ALU_AND:  alu_y = a_q & b_q;
            ALU_OR:   alu_y = a_q | b_q;
            ALU_XOR:  alu_y = a_q ^ b_q;
            ALU_NOR:  alu_y = ~(a_q | b_q);
            ALU_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            ALU_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            default:  alu_y = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            g_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= ALU_ADD;
            y_q   <= '0;
            z_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr   <= '0;
`endif
        end else begin
            state <= next;
            if (accept) begin
                a_q  <= sel_a;
                b_q  <= sel_b;
                op_q <= sel_op;
                g_q  <= g_idx;
            end
            if (state == EXEC) begin
                y_q <= alu_y;
                z_q <= (alu_y == '0);
            end
`ifndef ALU_ARB_FIXED_PRIO_EN
            if (state == RESP && bus.rsp_ready[g_q]) begin
                ptr <= (g_q == PW'(NREQ-1)) ? '0 : g_q + 1'b1;
            end
`endif
        end
    end

    assign bus.rsp_y = y_q;
    assign bus.rsp_z = z_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vectors, corner sequences, random ops.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NREQ  = 2;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;

    logic [31:0] a_v [2];
    logic [31:0] b_v [2];
    logic [2:0]  op_v[2];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        z;
        string       name;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~(a | b);
            3'd6: begin
                // differing signs: the negative operand is the smaller one
                if (a[31] != b[31]) return {31'b0, a[31]};
                return {31'b0, (a < b)};
            end
            default: return {31'b0, (a < b)};
        endcase
    endfunction

    function automatic int pick(input logic [1:0] m);
        for (int k = 0; k < 2; k++) begin
            int i;
            i = (m_ptr + k) % 2;
            if (m[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [1:0] oh(input int w);
        logic [1:0] r;
        r = 2'b01;
        return r << w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_ops();
        bus.req_a  = {a_v[1], a_v[0]};
        bus.req_b  = {b_v[1], b_v[0]};
        bus.req_op = {op_v[1], op_v[0]};
    endtask

    // Starts at a negedge in IDLE, ends at the negedge after the response completes.
    task automatic txn(input logic [1:0] vmask, input int w, input logic [31:0] ey,
                       input logic ez, input string tag);
        drive_ops();
        bus.req_valid = vmask;
        #1;
        chk({tag, ".grant"}, 32'(bus.req_ready), 32'(oh(w)));
        @(posedge clk); @(negedge clk);
        chk({tag, ".exec_rdy"}, 32'(bus.req_ready), 32'd0);
        chk({tag, ".exec_vld"}, 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        chk({tag, ".rsp_vld"}, 32'(bus.rsp_valid), 32'(oh(w)));
        chk({tag, ".y"}, bus.rsp_y, ey);
        chk({tag, ".z"}, 32'(bus.rsp_z), 32'(ez));
        chk({tag, ".rsp_rdy"}, 32'(bus.req_ready), 32'd0);
        @(posedge clk); @(negedge clk);
`ifndef ALU_ARB_FIXED_PRIO_EN
        m_ptr = (w + 1) % 2;
`endif
    endtask

    initial begin
        logic [1:0]  vm;
        logic [31:0] ey;
        int          w;

        tbl[0] = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, "add_ovf"};
        tbl[1] = '{ALU_SUB,  32'd5,        32'd5,        32'h00000000, 1'b1, "sub_zero"};
        tbl[2] = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, "slt_neg"};
        tbl[3] = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, "sltu_big"};
        tbl[4] = '{ALU_NOR,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, "nor_zero"};
        tbl[5] = '{ALU_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, "and"};
        tbl[6] = '{ALU_OR,   32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, "or"};
        tbl[7] = '{ALU_XOR,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b1, "xor_self"};

        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        a_v[0] = 32'd3;  b_v[0] = 32'd4;  op_v[0] = ALU_ADD;
        a_v[1] = 32'd10; b_v[1] = 32'd20; op_v[1] = ALU_SUB;
        drive_ops();

        repeat (3) @(negedge clk);
        chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst.rsp_y", bus.rsp_y, 32'd0);
        chk("rst.rsp_z", 32'(bus.rsp_z), 32'd0);

        rst_n = 1'b1;
        txn(2'b11, 0, 32'd7, 1'b0, "first");

        for (int i = 0; i < 8; i++) begin
            a_v[0] = tbl[i].a; b_v[0] = tbl[i].b; op_v[0] = tbl[i].op;
            txn(2'b01, 0, tbl[i].y, tbl[i].z, tbl[i].name);
        end

        for (int i = 0; i < 6; i++) begin
            for (int r = 0; r < 2; r++) begin
                a_v[r] = $urandom; b_v[r] = $urandom; op_v[r] = 3'($urandom_range(0, 7));
            end
            w  = pick(2'b11);
            ey = ref_alu(op_v[w], a_v[w], b_v[w]);
            txn(2'b11, w, ey, (ey == 32'd0), "contend");
        end

        // backpressure on requester 1; rsp_ready[0] high must be ignored
        a_v[1] = 32'h1234; b_v[1] = 32'h0034; op_v[1] = ALU_SUB;
        drive_ops();
        bus.rsp_ready = 2'b01;
        bus.req_valid = 2'b10;
        #1;
        chk("bp.grant", 32'(bus.req_ready), 32'b10);
        @(posedge clk); @(negedge clk);
        bus.req_valid = 2'b11;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.rsp_valid", 32'(bus.rsp_valid), 32'b10);
            chk("bp.rsp_y", bus.rsp_y, 32'h1200);
            chk("bp.req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 2'b11;
        @(posedge clk); @(negedge clk);
`ifndef ALU_ARB_FIXED_PRIO_EN
        m_ptr = 0;
`endif
        chk("bp.release_vld", 32'(bus.rsp_valid), 32'd0);
        chk("bp.release_grant", 32'(bus.req_ready), 32'(oh(pick(2'b11))));
        bus.req_valid = 2'b00;
        #1;
        chk("bp.idle_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);

        a_v[0] = 32'd1; b_v[0] = 32'd1; op_v[0] = ALU_AND;
        txn(2'b01, 0, 32'd1, 1'b0, "pre_rst");

        // reset during EXEC: nothing may be returned, pointer goes back to 0
        a_v[0] = 32'd5; b_v[0] = 32'd6; op_v[0] = ALU_ADD;
        drive_ops();
        bus.req_valid = 2'b01;
        #1;
        chk("mid.grant", 32'(bus.req_ready), 32'b01);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid.rsp_y", bus.rsp_y, 32'd0);
        chk("mid.req_ready", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        m_ptr = 0;
        a_v[0] = 32'd9; b_v[0] = 32'd2; op_v[0] = ALU_SUB;
        a_v[1] = 32'd9; b_v[1] = 32'd2; op_v[1] = ALU_ADD;
        txn(2'b11, 0, 32'd7, 1'b0, "post_rst");

        for (int i = 0; i < 40; i++) begin
            vm = 2'($urandom_range(0, 3));
            for (int r = 0; r < 2; r++) begin
                op_v[r] = 3'($urandom_range(0, 7));
                a_v[r]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
                b_v[r]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            end
            if (vm == 2'b00) begin
                drive_ops();
                bus.req_valid = 2'b00;
                #1;
                chk("rnd.idle_ready", 32'(bus.req_ready), 32'd0);
                @(posedge clk); @(negedge clk);
                chk("rnd.idle_vld", 32'(bus.rsp_valid), 32'd0);
            end else begin
                w  = pick(vm);
                ey = ref_alu(op_v[w], a_v[w], b_v[w]);
                txn(vm, w, ey, (ey == 32'd0), "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
